// File: rtl/loop_stack.sv
`timescale 1ns/1ps
// loop_stack: loop-return stack for the BeeF core plus a forward bracket-skip tracker.
//   Holds PC values of open '[' loops. It pushes on loop entry, shows the top entry for
//   the ']' back-jump, and pops on loop exit. While fetch scans forward past a loop whose
//   accumulator was zero at '[', the skip FSM counts bracket nesting.
// Ports:
//   clk, reset (async, active low), clear (sync flush, highest priority)
//   push/pop/push_data      stack operations, honoured only while not skipping
//   skip_start/open/close   bracket-skip control from fetch/decode
//   top, count, empty, full stack state (registered / decoded from registers)
//   overflow, underflow     sticky error flags
//   skipping, skip_done     skip FSM status; skip_done pulses once when the scan ends
module loop_stack #(
  parameter  int unsigned ADDR_W = 8,
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned NEST_W = 8,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              skip_start,
  input  logic              skip_open,
  input  logic              skip_close,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              skipping,
  output logic              skip_done
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [NEST_W-1:0] NEST_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SKIP = 1'b1
  } state_e;

  logic [ADDR_W-1:0] mem [DEPTH];

  state_e            state_q,     state_d;
  logic [NEST_W-1:0] nest_q,      nest_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [ADDR_W-1:0] top_q,       top_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;
  logic              skip_done_q, skip_done_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic              full_c;
  logic              empty_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  // Next-state logic for the stack and the skip FSM
  always_comb begin
    state_d     = state_q;
    nest_d      = nest_q;
    count_d     = count_q;
    top_d       = top_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    skip_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;

    if (clear) begin
      state_d     = S_IDLE;
      nest_d      = '0;
      count_d     = '0;
      top_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (state_q == S_IDLE) begin
      if (push && pop && !empty_c) begin
        // Replace the top entry in place
        mem_we    = 1'b1;
        mem_waddr = IDX_W'(count_q - CNT_W'(1));
        top_d     = push_data;
      end else if (push) begin
        // Also covers push&pop on an empty stack, which acts as a plain push
        if (!full_c) begin
          mem_we    = 1'b1;
          mem_waddr = IDX_W'(count_q);
          count_d   = count_q + CNT_W'(1);
          top_d     = push_data;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (pop) begin
        if (count_q >= CNT_W'(2)) begin
          count_d = count_q - CNT_W'(1);
          top_d   = mem[IDX_W'(count_q - CNT_W'(2))];
        end else if (count_q == CNT_W'(1)) begin
          count_d = '0;
          top_d   = '0;
        end else begin
          underflow_d = 1'b1;
        end
      end

      if (skip_start) begin
        state_d = S_SKIP;
        nest_d  = NEST_W'(1);
      end
    end else begin
      // Opening and closing in the same cycle cancel out
      if (skip_open && !skip_close) begin
        if (nest_q == NEST_MAX) begin
          overflow_d = 1'b1;
        end else begin
          nest_d = nest_q + NEST_W'(1);
        end
      end else if (skip_close && !skip_open) begin
        if (nest_q > NEST_W'(1)) begin
          nest_d = nest_q - NEST_W'(1);
        end else begin
          state_d     = S_IDLE;
          nest_d      = '0;
          skip_done_d = 1'b1;
        end
      end
    end
  end

  // State and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      nest_q      <= '0;
      count_q     <= '0;
      top_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      skip_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nest_q      <= nest_d;
      count_q     <= count_d;
      top_q       <= top_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      skip_done_q <= skip_done_d;
    end
  end

  // Storage array; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= push_data;
    end
  end

  assign top       = top_q;
  assign count     = count_q;
  assign empty     = empty_c;
  assign full      = full_c;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign skipping  = (state_q == S_SKIP);
  assign skip_done = skip_done_q;

endmodule
